// File: rtl/chase_pkg.sv
// Shared types and constants for the cat/mouse chase engine: game states,
// move directions, LFSR seed/taps and small decode helpers.
package chase_pkg;

    typedef enum logic [1:0] {
        IDLE,
        PLAY,
        OVER
    } state_t;

    typedef enum logic [2:0] {
        NONE,
        UP,
        DOWN,
        LEFT,
        RIGHT
    } dir_t;

    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    // Fibonacci taps 16,14,13,11 expressed as bit positions 15,13,12,10
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    function automatic logic [15:0] lfsr_next(input logic [15:0] l);
        return {l[14:0], ^(l & LFSR_TAPS)};
    endfunction

    // Only one direction is ever applied: up > down > left > right
    function automatic dir_t dir_decode(input logic u, input logic d,
                                        input logic l, input logic r);
        dir_t dir;
        if (u)      dir = UP;
        else if (d) dir = DOWN;
        else if (l) dir = LEFT;
        else if (r) dir = RIGHT;
        else        dir = NONE;
        return dir;
    endfunction

endpackage

// File: rtl/chase_actor_step.sv
// Combinational one-cell step of an actor on the grid. Edge behaviour is
// selected by MOVE_WRAP_EN: defined wraps to the opposite edge, undefined clamps.
module chase_actor_step
    import chase_pkg::*;
#(
    parameter int COORD_W = 4,
    parameter int GRID_X  = 16,
    parameter int GRID_Y  = 12
) (
    input  logic [COORD_W-1:0] i_x,
    input  logic [COORD_W-1:0] i_y,
    input  dir_t               i_dir,
    output logic [COORD_W-1:0] o_x,
    output logic [COORD_W-1:0] o_y
);

    localparam logic [COORD_W-1:0] XMAX = COORD_W'(GRID_X - 1);
    localparam logic [COORD_W-1:0] YMAX = COORD_W'(GRID_Y - 1);
    localparam logic [COORD_W-1:0] ONE  = COORD_W'(1);

`ifdef MOVE_WRAP_EN
    localparam logic [COORD_W-1:0] X_BELOW_0   = XMAX;
    localparam logic [COORD_W-1:0] X_ABOVE_MAX = '0;
    localparam logic [COORD_W-1:0] Y_BELOW_0   = YMAX;
    localparam logic [COORD_W-1:0] Y_ABOVE_MAX = '0;
`else
    localparam logic [COORD_W-1:0] X_BELOW_0   = '0;
    localparam logic [COORD_W-1:0] X_ABOVE_MAX = XMAX;
    localparam logic [COORD_W-1:0] Y_BELOW_0   = '0;
    localparam logic [COORD_W-1:0] Y_ABOVE_MAX = YMAX;
`endif

    // Y=0 is the top row, so up decrements Y
    always_comb begin
        o_x = i_x;
        o_y = i_y;
        case (i_dir)
            UP:      o_y = (i_y == '0)   ? Y_BELOW_0   : i_y - ONE;
            DOWN:    o_y = (i_y == YMAX) ? Y_ABOVE_MAX : i_y + ONE;
            LEFT:    o_x = (i_x == '0)   ? X_BELOW_0   : i_x - ONE;
            RIGHT:   o_x = (i_x == XMAX) ? X_ABOVE_MAX : i_x + ONE;
            default: ;
        endcase
    end

endmodule

// File: rtl/chase_location_engine.sv
// Cat/mouse position engine: tick-divided movement, goal capture scoring and
// catch detection. Optional edge wrap via MOVE_WRAP_EN (see chase_actor_step).
module chase_location_engine
    import chase_pkg::*;
#(
    parameter int COORD_W     = 4,
    parameter int GRID_X      = 16,
    parameter int GRID_Y      = 12,
    parameter int MOVE_DIV    = 2500000,
    parameter int SCORE_W     = 14,
    parameter int SCORE_MAX   = 9999,
    parameter int GOAL_POINTS = 1
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               start,
    input  logic               upBtn,
    input  logic               downBtn,
    input  logic               leftBtn,
    input  logic               rightBtn,
    input  logic               cupBtn,
    input  logic               cdownBtn,
    input  logic               cleftBtn,
    input  logic               crightBtn,
    output logic [COORD_W-1:0] CatX,
    output logic [COORD_W-1:0] CatY,
    output logic [COORD_W-1:0] MouseX,
    output logic [COORD_W-1:0] MouseY,
    output logic [COORD_W-1:0] GoalX,
    output logic [COORD_W-1:0] GoalY,
    output logic [SCORE_W-1:0] Score,
    output logic               GameOver
);

    localparam int                 CNT_W    = $clog2(MOVE_DIV);
    localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(MOVE_DIV - 1);
    localparam logic [COORD_W-1:0] XMAX     = COORD_W'(GRID_X - 1);
    localparam logic [COORD_W-1:0] YMAX     = COORD_W'(GRID_Y - 1);
    localparam logic [COORD_W-1:0] GX_HOME  = COORD_W'(GRID_X / 2);
    localparam logic [COORD_W-1:0] GY_HOME  = COORD_W'(GRID_Y / 2);
    localparam logic [COORD_W:0]   GX_EXT   = (COORD_W + 1)'(GRID_X);
    localparam logic [COORD_W:0]   GY_EXT   = (COORD_W + 1)'(GRID_Y);
    localparam logic [COORD_W-1:0] GX_LOW   = COORD_W'(GRID_X);
    localparam logic [COORD_W-1:0] GY_LOW   = COORD_W'(GRID_Y);

    state_t             r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic [15:0]        r_lfsr;
    logic               r_start_d;
    logic [COORD_W-1:0] r_cat_x, r_cat_y, r_mouse_x, r_mouse_y, r_goal_x, r_goal_y;
    logic [SCORE_W-1:0] r_score;
    logic               r_over;

    logic               w_start_rise, w_tick, w_catch, w_goal_hit;
    dir_t               w_cat_dir, w_mouse_dir;
    logic [COORD_W-1:0] w_cat_nx, w_cat_ny, w_mouse_nx, w_mouse_ny;
    logic [COORD_W-1:0] w_goal_x, w_goal_y;

    function automatic logic [SCORE_W-1:0] sat_add(input logic [SCORE_W-1:0] s);
        logic [SCORE_W:0] sum;
        sum = {1'b0, s} + (SCORE_W + 1)'(GOAL_POINTS);
        if (sum > (SCORE_W + 1)'(SCORE_MAX)) sat_add = SCORE_W'(SCORE_MAX);
        else                                 sat_add = sum[SCORE_W-1:0];
    endfunction

    function automatic logic on_actor(input logic [COORD_W-1:0] x, y, cx, cy, mx, my);
        return ((x == cx) && (y == cy)) || ((x == mx) && (y == my));
    endfunction

    function automatic logic [COORD_W-1:0] inc_x(input logic [COORD_W-1:0] x);
        return (x == XMAX) ? '0 : x + COORD_W'(1);
    endfunction

    assign w_start_rise = start & ~r_start_d;
    assign w_tick       = (r_state == PLAY) && (r_cnt == CNT_LAST);
    assign w_cat_dir    = dir_decode(cupBtn, cdownBtn, cleftBtn, crightBtn);
    assign w_mouse_dir  = dir_decode(upBtn, downBtn, leftBtn, rightBtn);

    chase_actor_step #(.COORD_W(COORD_W), .GRID_X(GRID_X), .GRID_Y(GRID_Y)) u_cat_step (
        .i_x(r_cat_x), .i_y(r_cat_y), .i_dir(w_cat_dir), .o_x(w_cat_nx), .o_y(w_cat_ny)
    );

    chase_actor_step #(.COORD_W(COORD_W), .GRID_X(GRID_X), .GRID_Y(GRID_Y)) u_mouse_step (
        .i_x(r_mouse_x), .i_y(r_mouse_y), .i_dir(w_mouse_dir), .o_x(w_mouse_nx), .o_y(w_mouse_ny)
    );

    // A swap of cells is not a catch: only the post-move cells are compared
    assign w_catch    = (w_cat_nx == w_mouse_nx) && (w_cat_ny == w_mouse_ny);
    assign w_goal_hit = (w_mouse_nx == r_goal_x) && (w_mouse_ny == r_goal_y) && !w_catch;

    // Goal candidate folded into the grid, then nudged right off any actor cell
    always_comb begin
        w_goal_x = r_lfsr[COORD_W-1:0];
        w_goal_y = r_lfsr[2*COORD_W-1:COORD_W];
        if ({1'b0, w_goal_x} >= GX_EXT) w_goal_x = w_goal_x - GX_LOW;
        if ({1'b0, w_goal_y} >= GY_EXT) w_goal_y = w_goal_y - GY_LOW;
        if (on_actor(w_goal_x, w_goal_y, w_cat_nx, w_cat_ny, w_mouse_nx, w_mouse_ny))
            w_goal_x = inc_x(w_goal_x);
        if (on_actor(w_goal_x, w_goal_y, w_cat_nx, w_cat_ny, w_mouse_nx, w_mouse_ny))
            w_goal_x = inc_x(w_goal_x);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state   <= IDLE;
            r_cnt     <= '0;
            r_lfsr    <= LFSR_SEED;
            r_start_d <= 1'b0;
            r_cat_x   <= '0;
            r_cat_y   <= '0;
            r_mouse_x <= XMAX;
            r_mouse_y <= YMAX;
            r_goal_x  <= GX_HOME;
            r_goal_y  <= GY_HOME;
            r_score   <= '0;
            r_over    <= 1'b0;
        end else begin
            r_lfsr    <= lfsr_next(r_lfsr);
            r_start_d <= start;
            case (r_state)
                IDLE, OVER: begin
                    if (w_start_rise) begin
                        r_state   <= PLAY;
                        r_cnt     <= '0;
                        r_cat_x   <= '0;
                        r_cat_y   <= '0;
                        r_mouse_x <= XMAX;
                        r_mouse_y <= YMAX;
                        r_goal_x  <= GX_HOME;
                        r_goal_y  <= GY_HOME;
                        r_score   <= '0;
                        r_over    <= 1'b0;
                    end
                end
                PLAY: begin
                    r_cnt <= w_tick ? '0 : r_cnt + CNT_W'(1);
                    if (w_tick) begin
                        r_cat_x   <= w_cat_nx;
                        r_cat_y   <= w_cat_ny;
                        r_mouse_x <= w_mouse_nx;
                        r_mouse_y <= w_mouse_ny;
                        if (w_catch) begin
                            r_state <= OVER;
                            r_over  <= 1'b1;
                        end else if (w_goal_hit) begin
                            r_score  <= sat_add(r_score);
                            r_goal_x <= w_goal_x;
                            r_goal_y <= w_goal_y;
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign CatX     = r_cat_x;
    assign CatY     = r_cat_y;
    assign MouseX   = r_mouse_x;
    assign MouseY   = r_mouse_y;
    assign GoalX    = r_goal_x;
    assign GoalY    = r_goal_y;
    assign Score    = r_score;
    assign GameOver = r_over;

endmodule

// File: tb/tb_chase_location_engine.sv
// Directed bench for chase_location_engine (MOVE_DIV=4, 16x12 grid).
module tb_chase_location_engine;

    localparam int CW = 4;
    localparam int GX = 16;
    localparam int GY = 12;
    localparam int MD = 4;

    localparam logic [3:0] B_U = 4'b1000;
    localparam logic [3:0] B_D = 4'b0100;
    localparam logic [3:0] B_L = 4'b0010;
    localparam logic [3:0] B_R = 4'b0001;
    localparam logic [3:0] B_0 = 4'b0000;

    logic clock = 1'b0;
    logic reset = 1'b1;
    logic start = 1'b0;
    logic upBtn = 1'b0, downBtn = 1'b0, leftBtn = 1'b0, rightBtn = 1'b0;
    logic cupBtn = 1'b0, cdownBtn = 1'b0, cleftBtn = 1'b0, crightBtn = 1'b0;
    logic [CW-1:0] CatX, CatY, MouseX, MouseY, GoalX, GoalY;
    logic [13:0]   Score;
    logic          GameOver;

    always #5 clock = ~clock;

    chase_location_engine #(
        .COORD_W(CW), .GRID_X(GX), .GRID_Y(GY), .MOVE_DIV(MD),
        .SCORE_W(14), .SCORE_MAX(9999), .GOAL_POINTS(1)
    ) dut (
        .clock(clock), .reset(reset), .start(start),
        .upBtn(upBtn), .downBtn(downBtn), .leftBtn(leftBtn), .rightBtn(rightBtn),
        .cupBtn(cupBtn), .cdownBtn(cdownBtn), .cleftBtn(cleftBtn), .crightBtn(crightBtn),
        .CatX(CatX), .CatY(CatY), .MouseX(MouseX), .MouseY(MouseY),
        .GoalX(GoalX), .GoalY(GoalY), .Score(Score), .GameOver(GameOver)
    );

    int total = 0;
    int bad   = 0;
    int ecx, ecy, emx, emy, egx, egy, esc, ego;

    // Reference LFSR; the previous value is what the DUT used on the last tick
    logic [15:0] tb_lf, tb_lf_prev;
    always @(posedge clock or negedge reset) begin
        if (!reset) begin
            tb_lf      <= 16'hACE1;
            tb_lf_prev <= 16'hACE1;
        end else begin
            tb_lf_prev <= tb_lf;
            tb_lf      <= {tb_lf[14:0], tb_lf[15] ^ tb_lf[13] ^ tb_lf[12] ^ tb_lf[10]};
        end
    end

    typedef struct {
        logic [3:0] cb;
        logic [3:0] mb;
        int cx, cy, mx, my;
    } vec_t;
    vec_t tbl [14];

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic check_all(input string nm);
        chk({nm, ".catx"},   CatX,     ecx);
        chk({nm, ".caty"},   CatY,     ecy);
        chk({nm, ".mousex"}, MouseX,   emx);
        chk({nm, ".mousey"}, MouseY,   emy);
        chk({nm, ".goalx"},  GoalX,    egx);
        chk({nm, ".goaly"},  GoalY,    egy);
        chk({nm, ".score"},  Score,    esc);
        chk({nm, ".over"},   GameOver, ego);
    endtask

    task automatic set_reset_exp();
        ecx = 0; ecy = 0; emx = GX - 1; emy = GY - 1;
        egx = GX / 2; egy = GY / 2; esc = 0; ego = 0;
    endtask

    task automatic goal_model(input logic [15:0] l, input int cx, cy, mx, my,
                              output int gx, output int gy);
        gx = int'(l[3:0]);
        gy = int'(l[7:4]);
        if (gx >= GX) gx -= GX;
        if (gy >= GY) gy -= GY;
        repeat (2)
            if ((gx == mx && gy == my) || (gx == cx && gy == cy))
                gx = (gx == GX - 1) ? 0 : gx + 1;
    endtask

    task automatic set_btn(input logic [3:0] cb, input logic [3:0] mb);
        {cupBtn, cdownBtn, cleftBtn, crightBtn} = cb;
        {upBtn, downBtn, leftBtn, rightBtn}     = mb;
    endtask

    // Called #1 after an update edge; the next update is MD edges later
    task automatic tick(input string nm, input logic [3:0] cb, input logic [3:0] mb,
                        input int ncx, ncy, nmx, nmy, input bit pulse);
        set_btn(cb, mb);
        if (pulse) start = 1'b0;
        repeat (MD - 1) begin
            @(posedge clock); #1;
            if (pulse) start = 1'b1;
        end
        chk({nm, ".hold_cx"}, CatX, ecx);
        chk({nm, ".hold_mx"}, MouseX, emx);
        @(posedge clock); #1;
        if (ncx == nmx && ncy == nmy) ego = 1;
        else if (nmx == egx && nmy == egy) begin
            esc = (esc + 1 > 9999) ? 9999 : esc + 1;
            goal_model(tb_lf_prev, ncx, ncy, nmx, nmy, egx, egy);
        end
        ecx = ncx; ecy = ncy; emx = nmx; emy = nmy;
        check_all(nm);
    endtask

    task automatic steer_cat(input int tx, input int ty);
        for (int i = 0; i < 40 && !(ecx == tx && ecy == ty); i++) begin
            int nx, ny;
            logic [3:0] b;
            nx = ecx; ny = ecy;
            if (ecx < tx)      begin b = B_R; nx++; end
            else if (ecx > tx) begin b = B_L; nx--; end
            else if (ecy < ty) begin b = B_D; ny++; end
            else               begin b = B_U; ny--; end
            tick("steer_cat", b, B_0, nx, ny, emx, emy, 1'b0);
        end
        chk("steer_cat.reached", int'(ecx == tx && ecy == ty), 1);
    endtask

    task automatic mstep(input int x, y, tx, ty, input bit xfirst,
                         output int nx, output int ny, output logic [3:0] b);
        nx = x; ny = y;
        if ((xfirst && x != tx) || (!xfirst && y == ty)) begin
            if (x < tx) begin b = B_R; nx++; end else begin b = B_L; nx--; end
        end else begin
            if (y < ty) begin b = B_D; ny++; end else begin b = B_U; ny--; end
        end
    endtask

    // Mouse walks to a target; if the cat sits in its only path the cat sidesteps
    task automatic steer_mouse(input int tx, input int ty);
        for (int i = 0; i < 60 && !(emx == tx && emy == ty); i++) begin
            int nx, ny, cnx, cny;
            logic [3:0] b, cb;
            mstep(emx, emy, tx, ty, 1'b1, nx, ny, b);
            if (nx == ecx && ny == ecy) mstep(emx, emy, tx, ty, 1'b0, nx, ny, b);
            if (nx == ecx && ny == ecy) begin
                cnx = ecx; cny = ecy;
                if (emy == ecy) begin
                    if (ecy > 0) begin cb = B_U; cny--; end else begin cb = B_D; cny++; end
                end else begin
                    if (ecx > 0) begin cb = B_L; cnx--; end else begin cb = B_R; cnx++; end
                end
                tick("mouse_dodge", cb, B_0, cnx, cny, emx, emy, 1'b0);
            end else begin
                tick("steer_mouse", B_0, b, ecx, ecy, nx, ny, 1'b0);
            end
        end
        chk("steer_mouse.reached", int'(emx == tx && emy == ty), 1);
    endtask

    task automatic restart();
        start = 1'b0;
        set_btn(B_0, B_0);
        @(posedge clock); #1;
        start = 1'b1;
        @(posedge clock); #1;
        set_reset_exp();
        check_all("restart");
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        int tx, ty;
        logic [3:0] cb, mb;

        tbl[0]  = '{B_R,        B_0,              1, 0, 15, 11};
        tbl[1]  = '{B_R,        B_U,              2, 0, 15, 10};
        tbl[2]  = '{B_R,        B_L,              3, 0, 14, 10};
        tbl[3]  = '{B_U | B_R,  B_U | B_D,        3, 0, 14,  9};
        tbl[4]  = '{B_D | B_L,  B_L | B_R,        3, 1, 13,  9};
        tbl[5]  = '{B_L | B_R,  B_D | B_L | B_R,  2, 1, 13, 10};
        tbl[6]  = '{B_0,        B_U,              2, 1, 13,  9};
        tbl[7]  = '{B_0,        B_U,              2, 1, 13,  8};
        tbl[8]  = '{B_0,        B_U,              2, 1, 13,  7};
        tbl[9]  = '{B_0,        B_U,              2, 1, 13,  6};
        tbl[10] = '{B_0,        B_L,              2, 1, 12,  6};
        tbl[11] = '{B_0,        B_L,              2, 1, 11,  6};
        tbl[12] = '{B_0,        B_L,              2, 1, 10,  6};
        tbl[13] = '{B_0,        B_L,              2, 1,  9,  6};

        // Reset values, then IDLE ignores held buttons
        set_btn(B_R, B_0);
        #2 reset = 1'b0;
        #1;
        set_reset_exp();
        check_all("rst_low");
        repeat (2) @(posedge clock);
        @(negedge clock) reset = 1'b1;
        repeat (10) @(posedge clock);
        #1;
        check_all("idle_hold");

        // Start; table of single-tick moves (entry 7 also re-pulses start in PLAY)
        start = 1'b1;
        @(posedge clock); #1;
        check_all("start_edge");
        for (int i = 0; i < 14; i++)
            tick($sformatf("vec%0d", i), tbl[i].cb, tbl[i].mb,
                 tbl[i].cx, tbl[i].cy, tbl[i].mx, tbl[i].my, i == 7);

        // First goal capture at (8,6)
        tick("cap1", B_0, B_L, 2, 1, 8, 6, 1'b0);
        chk("cap1.score_val", Score, 1);
        chk("cap1.goal_x_range", int'(GoalX < GX), 1);
        chk("cap1.goal_y_range", int'(GoalY < GY), 1);
        chk("cap1.goal_not_mouse", int'(GoalX == MouseX && GoalY == MouseY), 0);
        chk("cap1.goal_not_cat", int'(GoalX == CatX && GoalY == CatY), 0);

        // Second capture at the relocated goal
        steer_mouse(egx, egy);
        chk("cap2.score_val", Score, 2);
        chk("cap2.goal_not_mouse", int'(GoalX == MouseX && GoalY == MouseY), 0);

        // Park the cat beside the mouse, swap cells (no catch), then catch
        tx = (ecx <= emx && emx > 0) ? emx - 1 : emx + 1;
        ty = emy;
        steer_cat(tx, ty);
        if (tx < emx) begin cb = B_R; mb = B_L; end else begin cb = B_L; mb = B_R; end
        tick("swap", cb, mb, emx, emy, ecx, ecy, 1'b0);
        chk("swap.no_catch", GameOver, 0);
        tick("catch", mb, B_0, emx, emy, emx, emy, 1'b0);
        chk("catch.over", GameOver, 1);

        // OVER freezes everything
        set_btn(4'b1111, 4'b1111);
        repeat (20) @(posedge clock);
        #1;
        check_all("over_hold");

        // Restart; mouse pushes right against the corner
        restart();
`ifdef MOVE_WRAP_EN
        tick("edge_right", B_0, B_R, 0, 0, 0, 11, 1'b0);
`else
        tick("edge_right", B_0, B_R, 0, 0, 15, 11, 1'b0);
`endif

        // Cat and mouse step onto the goal together: catch wins
        steer_cat(7, 6);
        steer_mouse(9, 6);
        tick("catch_goal", B_R, B_L, 8, 6, 8, 6, 1'b0);
        chk("catch_goal.score_val", Score, 0);
        chk("catch_goal.goal_x", GoalX, 8);

        // Asynchronous reset between clock edges in the middle of a game
        restart();
        tick("pre_rst", B_R, B_0, 1, 0, 15, 11, 1'b0);
        #3 reset = 1'b0;
        #1;
        set_reset_exp();
        check_all("async_rst");
        reset = 1'b1;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/chase_location_engine.md
Name: chase_location_engine

Overview:
Parametrised next-generation cat/mouse position engine. Holds cat, mouse and goal grid coordinates, advances the actors on a divided move tick from held direction buttons, scores goal captures, and flags game-over on collision. Sits between the debounced button inputs and the display/score drivers.

Parameters:
COORD_W, 4, bits per coordinate
GRID_X, 16, columns; legal X is 0..GRID_X-1; requires 2^(COORD_W-1) < GRID_X <= 2^COORD_W
GRID_Y, 12, rows; same constraint as GRID_X
MOVE_DIV, 2500000, clock cycles per move tick (>=2)
SCORE_W, 14, score width
SCORE_MAX, 9999, score saturation value
GOAL_POINTS, 1, points per goal capture

Ports:
clock  in  1  system clock
reset  in  1  asynchronous, active-low reset
start  in  1  level; rising edge starts or restarts a game
upBtn, downBtn, leftBtn, rightBtn  in  1 each  mouse direction, debounced levels
cupBtn, cdownBtn, cleftBtn, crightBtn  in  1 each  cat direction, debounced levels
CatX, CatY  out  COORD_W each  cat position
MouseX, MouseY  out  COORD_W each  mouse position
GoalX, GoalY  out  COORD_W each  goal position
Score  out  SCORE_W  goals scored
GameOver  out  1  high while in OVER

Behaviour:
- Reset (reset==0, async): Cat=(0,0), Mouse=(GRID_X-1,GRID_Y-1), Goal=(GRID_X/2,GRID_Y/2), Score=0, GameOver=0, state=IDLE, tick counter=0, LFSR=16'hACE1, start edge register=0.
- States:
  - IDLE -> PLAY on start rising edge.
  - PLAY -> OVER on catch.
  - OVER -> PLAY on start rising edge. Restart reloads the reset positions and goal and clears Score; the LFSR is not reloaded.
- Tick counter runs only in PLAY. It clears on entry to PLAY and pulses every MOVE_DIV cycles: the first tick falls on the MOVE_DIV-th PLAY cycle.
- On a tick, each actor moves one cell. Priority is up > down > left > right; only one direction is applied. No button held means no move.
- Y=0 is the top row: up decrements Y, down increments Y.
- Edges: clamp at 0 and at GRID-1 (see optional feature).
- Outputs are registered. New positions appear one clock after the tick cycle.
- Catch: the updated cat position equals the updated mouse position. GameOver rises in the same cycle the positions update.
- Cat and mouse swapping cells on one tick is not a catch.
- Goal capture: the updated mouse position equals the goal and there is no catch.
  - Score += GOAL_POINTS, saturating at SCORE_MAX.
  - Goal relocates in the same update. X = LFSR[COORD_W-1:0], minus GRID_X if >= GRID_X. Y = LFSR[2*COORD_W-1:COORD_W], minus GRID_Y if >= GRID_Y.
  - If the new goal equals the updated cat or mouse cell, increment X (wrapping GRID_X-1 -> 0) once, then again if it still collides.
- Catch and goal on the same tick: the catch wins; no score, goal unchanged.
- LFSR: 16-bit Fibonacci, taps 16,14,13,11. Advances every clock in all states except reset.
- In IDLE and OVER, buttons are ignored and positions are frozen.
- A start edge during PLAY is ignored.
- Reset mid-game returns to the reset state immediately, without waiting for a clock edge.

Optional Feature:
MOVE_WRAP_EN
- Defined: moving off an edge wraps to the opposite edge (X GRID_X-1 -> 0 and 0 -> GRID_X-1; Y likewise).
- Undefined: coordinates clamp at the edges.
- All other behaviour is identical.

Decomposition:
- Shared package chase_pkg holds:
  - state enum: IDLE, PLAY, OVER
  - direction enum: NONE, UP, DOWN, LEFT, RIGHT
  - LFSR seed and tap constants
- One sub-module, chase_actor_step, instantiated twice:
  - combinational next-position function of position, direction and grid bounds
  - honours MOVE_WRAP_EN

Test Plan (MOVE_DIV=4, GRID_X=16, GRID_Y=12, COORD_W=4):
1. Reset low then high -> Cat (0,0), Mouse (15,11), Goal (8,6), Score 0, GameOver 0; held crightBtn causes no motion until start.
2. Start edge, hold crightBtn -> CatX goes 0,1,2,3 at 4-cycle spacing; CatY stays 0.
3. Start, hold rightBtn with the mouse at (15,11) -> clamp build: MouseX stays 15; MOVE_WRAP_EN build: MouseX becomes 0 after the first tick.
4. Steer the mouse onto (8,6) -> Score 1; new goal in range and not equal to the mouse or cat cell; a repeat capture gives Score 2.
5. Steer the cat onto the mouse -> GameOver 1 in the update cycle; 20 further cycles of buttons leave positions unchanged; a start edge restores (0,0)/(15,11)/(8,6), Score 0, GameOver 0.
6. Assert reset mid-PLAY between clock edges -> all outputs return to reset values before the next clock edge.
